// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage and its consumers.
// Execute imports the operand bundle layout from here.
package operand_fetch_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int CTRL_W_DEFAULT = 16;
    localparam int REG_IDX_W      = 5;
    localparam int NUM_REGS       = 32;

    localparam logic [REG_IDX_W-1:0] X0 = '0;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0]   rs1_data;
        logic [XLEN_DEFAULT-1:0]   rs2_data;
        logic [REG_IDX_W-1:0]      rd;
        logic                      rd_we;
        logic [CTRL_W_DEFAULT-1:0] ctrl;
    } operand_bundle_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus the
// RAW hazard lookup for both source operands.
module reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic                 byp_en,
    input  logic [REG_IDX_W-1:0] byp_idx,
    input  logic                 held_en,
    input  logic [REG_IDX_W-1:0] held_idx,
    input  logic                 rs1_used,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic                 rs2_used,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 hz_rs1,
    output logic                 hz_rs2,
    output logic [NUM_REGS-1:0]  busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Set is applied after clear: the issuing instruction is younger than the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[X0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    function automatic logic src_hazard(input logic                 used,
                                        input logic [REG_IDX_W-1:0] idx,
                                        input logic [NUM_REGS-1:0]  busy,
                                        input logic                 wb_hit_en,
                                        input logic [REG_IDX_W-1:0] wb_idx,
                                        input logic                 held_hit_en,
                                        input logic [REG_IDX_W-1:0] held_rd);
        logic pend, wb_hit, held_hit;
        pend     = busy[idx] & !(wb_hit_en & (wb_idx == idx));
        held_hit = held_hit_en & (held_rd == idx);
        wb_hit   = pend | held_hit;
        return used & (idx != X0) & wb_hit;
    endfunction

    assign hz_rs1   = src_hazard(rs1_used, rs1, busy_q, byp_en, byp_idx, held_en, held_idx);
    assign hz_rs2   = src_hazard(rs2_used, rs2, busy_q, byp_en, byp_idx, held_en, held_idx);
    assign busy_vec = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register file read, writeback bypass, RAW stall via the
// scoreboard, and a one-entry valid/ready register toward execute.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rs1_used,
    input  logic                 in_rs2_used,
    input  logic                 in_rd_we,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic [REG_IDX_W-1:0] rf_rs1,
    output logic [REG_IDX_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic                 wb_valid,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_we,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic                 hazard_stall,
    output logic [NUM_REGS-1:0]  busy_vec
);

    logic                 vld_p1;
    logic [XLEN-1:0]      rs1_data_p1;
    logic [XLEN-1:0]      rs2_data_p1;
    logic [REG_IDX_W-1:0] rd_p1;
    logic                 rd_we_p1;
    logic [CTRL_W-1:0]    ctrl_p1;

    logic wb_byp, hz_rs1, hz_rs2, slot_free, in_fire, out_fire, issue;

    // The register file writes at the edge, so a same-cycle retire must be forwarded here.
    function automatic logic [XLEN-1:0] sel_operand(input logic [REG_IDX_W-1:0] idx,
                                                    input logic [XLEN-1:0]      rf,
                                                    input logic                 byp,
                                                    input logic [REG_IDX_W-1:0] byp_idx,
                                                    input logic [XLEN-1:0]      byp_data);
        if (idx == X0)                   return '0;
        else if (byp && (byp_idx == idx)) return byp_data;
        else                             return rf;
    endfunction

    assign rf_rs1       = in_rs1;
    assign rf_rs2       = in_rs2;
    assign wb_byp       = wb_valid & wb_we;
    assign hazard_stall = in_valid & (hz_rs1 | hz_rs2);
    assign slot_free    = !vld_p1 | out_ready;
    assign in_ready     = !hazard_stall & slot_free & !flush;
    assign in_fire      = in_valid & in_ready;
    assign out_fire     = vld_p1 & out_ready;
    assign issue        = out_fire & !flush & rd_we_p1;

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue),
        .set_idx  (rd_p1),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .byp_en   (wb_byp),
        .byp_idx  (wb_rd),
        .held_en  (vld_p1 & rd_we_p1),
        .held_idx (rd_p1),
        .rs1_used (in_rs1_used),
        .rs1      (in_rs1),
        .rs2_used (in_rs2_used),
        .rs2      (in_rs2),
        .hz_rs1   (hz_rs1),
        .hz_rs2   (hz_rs2),
        .busy_vec (busy_vec)
    );

    // ---- p1: decode -> execute holding register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            rd_p1       <= '0;
            rd_we_p1    <= 1'b0;
            ctrl_p1     <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1      <= 1'b1;
            rs1_data_p1 <= sel_operand(in_rs1, rf_rdata1, wb_byp, wb_rd, wb_data);
            rs2_data_p1 <= sel_operand(in_rs2, rf_rdata2, wb_byp, wb_rd, wb_data);
            rd_p1       <= in_rd;
            rd_we_p1    <= in_rd_we;
            ctrl_p1     <= in_ctrl;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = vld_p1;
    assign out_rs1_data = rs1_data_p1;
    assign out_rs2_data = rs2_data_p1;
    assign out_rd       = rd_p1;
    assign out_rd_we    = rd_we_p1;
    assign out_ctrl     = ctrl_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by randomized traffic
// checked against a register-level behavioural model.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_used, in_rs2_used, in_rd_we;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] out_ctrl;
    logic        hazard_stall;
    logic [31:0] busy_vec;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd_we(in_rd_we),
        .in_ctrl(in_ctrl),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl),
        .hazard_stall(hazard_stall), .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: which registers have an outstanding write, and the held instruction.
    bit          m_busy [32];
    bit          m_vld;
    logic [31:0] m_d1, m_d2;
    bit          m_u1, m_u2;
    logic [4:0]  m_rd;
    bit          m_we;
    logic [15:0] m_ctrl;
    logic [5:0]  issued [$];

    logic        obs_ready, obs_stall;
    logic [31:0] snap_d1, snap_d2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_vld = 0; m_d1 = '0; m_d2 = '0; m_u1 = 1; m_u2 = 1;
        m_rd = '0; m_we = 0; m_ctrl = '0;
        issued.delete();
    endtask

    function automatic logic [31:0] busy_pack();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit src_blocked(bit used, logic [4:0] s);
        if (!used || s == 0) return 0;
        if (m_busy[s] && !(wb_valid && wb_we && wb_rd == s)) return 1;
        if (m_vld && m_we && m_rd == s) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] operand(logic [4:0] idx, logic [31:0] rf);
        if (idx == 0) return 32'h0;
        if (wb_valid && wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_used = 0; in_rs2_used = 0; in_rd_we = 0; in_ctrl = 0;
        rf_rdata1 = 0; rf_rdata2 = 0;
        wb_valid = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    // One clock: inputs already driven in the low phase; check combinational
    // outputs, advance the model, then check registered outputs after the edge.
    task automatic cyc();
        bit stall, rdy, fire_in, fire_out;
        #1;
        stall = in_valid && (src_blocked(in_rs1_used, in_rs1) || src_blocked(in_rs2_used, in_rs2));
        rdy   = !stall && (!m_vld || out_ready) && !flush;
        obs_ready = in_ready;
        obs_stall = hazard_stall;
        chk("hazard_stall", 64'(hazard_stall), 64'(stall));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("rf_rs1", 64'(rf_rs1), 64'(in_rs1));
        chk("rf_rs2", 64'(rf_rs2), 64'(in_rs2));
        fire_in  = in_valid && rdy;
        fire_out = m_vld && out_ready;
        if (fire_out && !flush) issued.push_back({m_we, m_rd});
        if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 0;
        if (fire_out && !flush && m_we && m_rd != 0) m_busy[m_rd] = 1;
        if (flush) m_vld = 0;
        else if (fire_in) begin
            m_vld = 1;
            m_d1 = operand(in_rs1, rf_rdata1); m_u1 = in_rs1_used;
            m_d2 = operand(in_rs2, rf_rdata2); m_u2 = in_rs2_used;
            m_rd = in_rd; m_we = in_rd_we; m_ctrl = in_ctrl;
        end else if (fire_out) m_vld = 0;
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_vld));
        chk("busy_vec", 64'(busy_vec), 64'(busy_pack()));
        if (m_vld) begin
            chk("out_rd", 64'(out_rd), 64'(m_rd));
            chk("out_rd_we", 64'(out_rd_we), 64'(m_we));
            chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
            if (m_u1) chk("out_rs1_data", 64'(out_rs1_data), 64'(m_d1));
            if (m_u2) chk("out_rs2_data", 64'(out_rs2_data), 64'(m_d2));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] e;
        idle();
        rst_n = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset busy_vec", 64'(busy_vec), 64'(0));
        chk("reset out_rs1_data", 64'(out_rs1_data), 64'(0));
        chk("reset out_ctrl", 64'(out_ctrl), 64'(0));
        @(negedge clk);
        rst_n = 1;

        // Plain fetch from the register file
        in_valid = 1; in_rs1 = 5; in_rs2 = 6; in_rs1_used = 1; in_rs2_used = 1;
        in_rd = 3; in_ctrl = 16'hBEEF; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
        cyc();
        chk("t1 in_ready", 64'(obs_ready), 64'(1));
        chk("t1 rs1", 64'(out_rs1_data), 64'h11);
        chk("t1 rs2", 64'(out_rs2_data), 64'h22);
        chk("t1 valid", 64'(out_valid), 64'(1));
        in_valid = 0;
        cyc();
        chk("t1 in_ready idle", 64'(obs_ready), 64'(1));

        // Writeback bypass, and x0 stays zero under a bypass to x0
        idle();
        in_valid = 1; in_rs1 = 5; in_rs1_used = 1; rf_rdata1 = 32'hAAAA;
        wb_valid = 1; wb_we = 1; wb_rd = 5; wb_data = 32'h1234;
        cyc();
        chk("bypass rs1", 64'(out_rs1_data), 64'h1234);
        in_rs1 = 0; wb_rd = 0;
        cyc();
        chk("x0 under bypass", 64'(out_rs1_data), 64'h0);

        // RAW stall on rd=7
        idle();
        in_valid = 1; in_rd = 7; in_rd_we = 1;
        cyc();
        in_rd = 1; in_rd_we = 0; in_rs2 = 7; in_rs2_used = 1; rf_rdata2 = 32'hDEAD;
        cyc();
        chk("raw stall held", 64'(obs_stall), 64'(1));
        chk("raw in_ready held", 64'(obs_ready), 64'(0));
        chk("raw busy7 set", 64'(busy_vec[7]), 64'(1));
        cyc();
        chk("raw stall busy", 64'(obs_stall), 64'(1));
        wb_valid = 1; wb_we = 1; wb_rd = 7; wb_data = 32'h55;
        cyc();
        chk("raw accept on wb", 64'(obs_ready), 64'(1));
        chk("raw rs2 bypass", 64'(out_rs2_data), 64'h55);
        chk("raw busy7 clear", 64'(busy_vec[7]), 64'(0));

        // Backpressure with a held writer of x9
        idle();
        in_valid = 1; in_rd = 9; in_rd_we = 1; in_rs1 = 2; in_rs1_used = 1; rf_rdata1 = 32'h77;
        cyc();
        snap_d1 = out_rs1_data; snap_d2 = out_rs2_data;
        out_ready = 0; in_rs1 = 9; in_rd = 4; in_rd_we = 0; rf_rdata1 = 32'h1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp in_ready", 64'(obs_ready), 64'(0));
            chk("bp out_rd", 64'(out_rd), 64'(9));
            chk("bp hold rs1", 64'(out_rs1_data), 64'(snap_d1));
            chk("bp hold rs2", 64'(out_rs2_data), 64'(snap_d2));
        end
        out_ready = 1;
        cyc();
        chk("bp stall after ready", 64'(obs_stall), 64'(1));
        cyc();
        chk("bp stall on busy9", 64'(obs_stall), 64'(1));
        wb_valid = 1; wb_we = 1; wb_rd = 9; wb_data = 32'h99;
        cyc();
        chk("bp accept on wb", 64'(obs_ready), 64'(1));
        chk("bp rs1 bypass", 64'(out_rs1_data), 64'h99);

        // Flush kills the held x9 writer before it issues
        idle();
        in_valid = 1; in_rd = 9; in_rd_we = 1;
        cyc();
        flush = 1; in_rd = 5;
        cyc();
        chk("flush in_ready", 64'(obs_ready), 64'(0));
        chk("flush out_valid", 64'(out_valid), 64'(0));
        chk("flush busy9", 64'(busy_vec[9]), 64'(0));
        idle();
        in_valid = 0;
        cyc();
        chk("flush no capture", 64'(out_valid), 64'(0));

        // Asynchronous reset in the middle of a stall
        in_valid = 1; in_rd = 7; in_rd_we = 1;
        cyc();
        in_rd = 2; in_rd_we = 0;
        cyc();
        in_rd = 3; in_rs1 = 7; in_rs1_used = 1; out_ready = 0;
        #1;
        chk("pre-reset stall", 64'(hazard_stall), 64'(1));
        chk("pre-reset busy", 64'(busy_vec), 64'h80);
        chk("pre-reset valid", 64'(out_valid), 64'(1));
        rst_n = 0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'(0));
        chk("async busy_vec", 64'(busy_vec), 64'(0));
        chk("async out_rd", 64'(out_rd), 64'(0));
        chk("async out_rs1_data", 64'(out_rs1_data), 64'(0));
        model_reset();
        @(negedge clk);
        idle();
        rst_n = 1;

        // Randomized traffic; writebacks retire issued instructions in order
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(9, 0) < 7);
            in_rs1      = 5'($urandom_range(7, 0));
            in_rs2      = 5'($urandom_range(7, 0));
            in_rd       = 5'($urandom_range(7, 0));
            in_rs1_used = 1'($urandom_range(1, 0));
            in_rs2_used = 1'($urandom_range(1, 0));
            in_rd_we    = 1'($urandom_range(1, 0));
            in_ctrl     = 16'($urandom);
            rf_rdata1   = $urandom;
            rf_rdata2   = $urandom;
            out_ready   = ($urandom_range(3, 0) != 0);
            flush       = ($urandom_range(19, 0) == 0);
            wb_data     = $urandom;
            if (issued.size() > 0 && $urandom_range(1, 0) == 1) begin
                e = issued.pop_front();
                wb_valid = 1; wb_we = e[5]; wb_rd = e[4:0];
            end else begin
                wb_valid = 0; wb_we = 0; wb_rd = 5'($urandom_range(7, 0));
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
